// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unit computing P = Q*B + R, one partial product per clock.
// Used downstream of the restoring divider to rebuild the dividend.
module multiplicador_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   Q,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_q;
    logic [2*N-1:0]   r_b;
    logic [2*N-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_p;
    logic             w_accept;
    logic             w_last;
    logic [2*N-1:0]   w_sum;

    // start is only honoured outside CALC, so DONE can chain straight into a new job
    assign w_accept = start && (r_state != S_CALC);
    assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(N - 1));
    assign w_sum    = r_acc + (r_q[0] ? r_b : '0);

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_CALC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_q   <= Q;
                r_b   <= {{N{1'b0}}, B};
                r_acc <= {{N{1'b0}}, R};
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_sum;
                r_b   <= r_b << 1;
                r_q   <= r_q >> 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_p <= w_sum;
            end
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq: vector table, random ops, handshake corners.
// Covers N=4 and an N=8 instance.
module tb_multiplicador_seq;

    localparam int N  = 4;
    localparam int N8 = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    Q, B, R;
    logic            busy, done;
    logic [2*N-1:0]  P;
    logic            start8;
    logic [N8-1:0]   Q8, B8, R8;
    logic            busy8, done8;
    logic [2*N8-1:0] P8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiplicador_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Q(Q), .B(B), .R(R),
        .busy(busy), .done(done), .P(P)
    );

    multiplicador_seq #(.N(N8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .Q(Q8), .B(B8), .R(R8),
        .busy(busy8), .done(done8), .P(P8)
    );

    typedef struct {
        logic [N-1:0]   q;
        logic [N-1:0]   b;
        logic [N-1:0]   r;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic
    function automatic logic [31:0] model(input int w, input int q,
                                          input int b, input int r);
        return 32'((q * b + r) % (1 << (2 * w)));
    endfunction

    task automatic launch(input logic [N-1:0] q, input logic [N-1:0] b,
                          input logic [N-1:0] r);
        @(negedge clk);
        Q = q; B = b; R = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of cycle 1 after accept; returns cycle of done
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input string name, input logic [N-1:0] q,
                        input logic [N-1:0] b, input logic [N-1:0] r,
                        input logic [31:0] exp);
        int lat, bc;
        launch(q, b, r);
        Q = N'($urandom);
        B = N'($urandom);
        R = N'($urandom);
        wait_done(lat, bc);
        chk({name, "_lat"}, 32'(lat), 32'(N + 1));
        chk({name, "_busy"}, 32'(bc), 32'(N));
        chk({name, "_P"}, 32'(P), exp);
        @(negedge clk);
        chk({name, "_pulse"}, 32'(done), 32'd0);
        chk({name, "_hold"}, 32'(P), exp);
    endtask

    task automatic run8(input string name, input logic [N8-1:0] q,
                        input logic [N8-1:0] b, input logic [N8-1:0] r,
                        input logic [31:0] exp);
        int lat;
        @(negedge clk);
        Q8 = q; B8 = b; R8 = r; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(N8 + 1));
        chk({name, "_P"}, 32'(P8), exp);
    endtask

    initial begin
        int lat, bc, ndone, dcyc;
        logic [N-1:0] rq, rb, rr;

        tbl[0] = '{q: 4'd4,  b: 4'd3,  r: 4'd1,  p: 8'd13};
        tbl[1] = '{q: 4'd15, b: 4'd15, r: 4'd15, p: 8'd240};
        tbl[2] = '{q: 4'd9,  b: 4'd0,  r: 4'd7,  p: 8'd7};
        tbl[3] = '{q: 4'd0,  b: 4'd11, r: 4'd0,  p: 8'd0};

        rst = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
        start8 = 1'b0; Q8 = '0; B8 = '0; R8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_P", 32'(P), 32'd0);
        chk("rst_P8", 32'(P8), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run4($sformatf("tbl%0d", i), tbl[i].q, tbl[i].b, tbl[i].r,
                 32'(tbl[i].p));

        for (int i = 0; i < 16; i++) begin
            rq = N'($urandom); rb = N'($urandom); rr = N'($urandom);
            run4($sformatf("rnd%0d", i), rq, rb, rr,
                 model(N, int'(rq), int'(rb), int'(rr)));
        end

        // start pulse while busy must be dropped
        @(negedge clk);
        Q = 4'd2; B = 4'd5; R = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        Q = 4'd3; B = 4'd3; R = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        dcyc  = 0;
        for (int c = 3; c < 15; c++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = c;
                    chk("ign_P", 32'(P), 32'd10);
                end
            end
            @(negedge clk);
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_cycle", 32'(dcyc), 32'(N + 1));

        // reset in the middle of CALC
        launch(4'd5, 4'd5, 4'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_P", 32'(P), 32'd0);
        run4("post_rst", 4'd7, 4'd9, 4'd3, 32'd66);

        // back-to-back: start held in DONE cycle
        launch(4'd4, 4'd3, 4'd1);
        wait_done(lat, bc);
        chk("b2b_lat1", 32'(lat), 32'(N + 1));
        chk("b2b_P1", 32'(P), 32'd13);
        Q = 4'd6; B = 4'd7; R = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_nogap", 32'(busy), 32'd1);
        wait_done(lat, bc);
        chk("b2b_lat2", 32'(lat), 32'(N + 1));
        chk("b2b_P2", 32'(P), 32'd44);

        run8("n8_max", 8'd255, 8'd255, 8'd255, 32'd65280);
        run8("n8_basic", 8'd4, 8'd3, 8'd1, 32'd13);
        for (int i = 0; i < 6; i++) begin
            logic [N8-1:0] q8, b8, r8;
            q8 = N8'($urandom); b8 = N8'($urandom); r8 = N8'($urandom);
            run8($sformatf("n8_rnd%0d", i), q8, b8, r8,
                 model(N8, int'(q8), int'(b8), int'(r8)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
